// File: rtl/ieee80211_descrambler.sv
// 802.11 receive descrambler (x^7 + x^4 + 1). The seed is recovered from the
// 7 zero SERVICE bits at the start of each frame; one registered AXI4-Stream stage.
module ieee80211_descrambler #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [3:0]       s_axis_tuser,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       m_axis_tuser,
  output logic [6:0]       seed
);

  localparam int unsigned LFSR_W   = 7;
  localparam int unsigned SVC_BITS = 7;

  typedef enum logic {
    ST_SEED = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] seed_state;
  logic [LFSR_W-1:0] walk;
  logic              fb;
  logic [WIDTH-1:0]  dout;
  logic              accept;
  logic              in_seed;

  // No bubble: a new beat can enter whenever the output slot empties this cycle.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign in_seed       = (state_q == ST_SEED);

  // Received SERVICE bits equal the feedback bits, newest in x1: x1 = r6 .. x7 = r0.
  always_comb begin
    seed_state = '0;
    for (int k = 0; k < int'(LFSR_W); k++) begin
      seed_state[k] = s_axis_tdata[int'(SVC_BITS) - 1 - k];
    end
  end

  // WIDTH unrolled LFSR steps; on a frame's first beat the SERVICE bits are
  // consumed by seed recovery and the walk starts at bit 7.
  always_comb begin
    walk = in_seed ? seed_state : lfsr_q;
    fb   = 1'b0;
    dout = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!(in_seed && (i < int'(SVC_BITS)))) begin
        fb      = walk[6] ^ walk[3];
        dout[i] = s_axis_tdata[i] ^ fb;
        walk    = {walk[5:0], fb};
      end
    end
    lfsr_d = walk;
  end

  // Frame-position state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: only accepted beats move the FSM; tlast returns to seed recovery.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = s_axis_tlast ? ST_SEED : ST_DATA;
    end
  end

  // LFSR, recovered seed and the output register stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q        <= '0;
      seed          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (accept) begin
        lfsr_q        <= lfsr_d;
        m_axis_tdata  <= dout;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tuser  <= s_axis_tuser;
        if (in_seed) begin
          seed <= seed_state;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ieee80211_descrambler.sv
// Directed bench for ieee80211_descrambler: frames are built by a TX-side
// scrambler model; outputs are checked against the plaintext and recovered seed.
module tb_ieee80211_descrambler;

  localparam int unsigned W = 24;

  logic         aclk;
  logic         aresetn;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [3:0]   s_axis_tuser;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [3:0]   m_axis_tuser;
  logic [6:0]   seed;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   user;
  } in_beat_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   user;
    logic [6:0]   seed;
  } exp_beat_t;

  in_beat_t  in_q[$];
  exp_beat_t exp_q[$];

  // Payload words; first word keeps its 16 SERVICE bits zero
  logic [W-1:0] payload [10] = '{24'h5A0000, 24'h3C1E87, 24'hDEADBE, 24'h0F0F0F, 24'h123456,
                                 24'hFEDCBA, 24'h808001, 24'h7FFF00, 24'hC3A596, 24'h00FF55};

  ieee80211_descrambler #(.WIDTH(W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .seed          (seed)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX scrambler model: plaintext pattern 0 = zeros, 1 = payload table, 2 = random.
  task automatic build_frame(input logic [6:0] init, input int n, input int pat, input logic [3:0] user0);
    logic [6:0]   s;
    logic [6:0]   sd;
    logic         f;
    logic [W-1:0] p;
    logic [W-1:0] c;
    s  = init;
    sd = '0;
    for (int b = 0; b < n; b++) begin
      case (pat)
        0:       p = '0;
        1:       p = payload[b % 10];
        default: p = W'($urandom);
      endcase
      if (b == 0) p[15:0] = '0;
      c = '0;
      for (int i = 0; i < int'(W); i++) begin
        f    = s[6] ^ s[3];
        c[i] = p[i] ^ f;
        s    = {s[5:0], f};
        if (b == 0 && i == 6) sd = s;
      end
      in_q.push_back('{data: c, last: (b == n - 1), user: user0 + 4'(b)});
      exp_q.push_back('{data: p, last: (b == n - 1), user: user0 + 4'(b), seed: sd});
    end
  endtask

  // Drives queued beats and checks each delivered beat; ready_mode 1 toggles
  // m_axis_tready 1010.., gap_mode 1 inserts random tvalid gaps; stop_after > 0
  // returns once that many beats have been accepted.
  task automatic run(input int ready_mode, input int gap_mode, input int stop_after, input int budget);
    int           cyc;
    int           acc;
    logic         stall;
    logic         took;
    logic [W-1:0] hd;
    logic         hl;
    logic [3:0]   hu;
    exp_beat_t    e;
    cyc   = 0;
    acc   = 0;
    stall = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    hu    = '0;
    while (exp_q.size() > 0 && cyc < budget && !(stop_after > 0 && acc >= stop_after)) begin
      m_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (in_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[0].data;
        s_axis_tlast  = in_q[0].last;
        s_axis_tuser  = in_q[0].user;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = W'($urandom);
        s_axis_tlast  = 1'($urandom);
        s_axis_tuser  = 4'($urandom);
      end
      #1;
      if (stall) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", 32'(m_axis_tdata), 32'(hd));
        chk("stall_last", 32'(m_axis_tlast), 32'(hl));
        chk("stall_user", 32'(m_axis_tuser), 32'(hu));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q.pop_front();
        chk("data", 32'(m_axis_tdata), 32'(e.data));
        chk("last", 32'(m_axis_tlast), 32'(e.last));
        chk("user", 32'(m_axis_tuser), 32'(e.user));
        chk("seed", 32'(seed), 32'(e.seed));
      end
      stall = m_axis_tvalid && !m_axis_tready;
      hd    = m_axis_tdata;
      hl    = m_axis_tlast;
      hu    = m_axis_tuser;
      took  = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (took) begin
        void'(in_q.pop_front());
        acc++;
      end
      cyc++;
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $error("FAIL budget: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
      in_q.delete();
      exp_q.delete();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_data", 32'(m_axis_tdata), 32'd0);
    chk("rst_last", 32'(m_axis_tlast), 32'd0);
    chk("rst_user", 32'(m_axis_tuser), 32'd0);
    chk("rst_seed", 32'(seed), 32'd0);
    chk("rst_ready", 32'(s_axis_tready), 32'd1);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // T1: zero plaintext, seed 1111111, 10 beats
    build_frame(7'b1111111, 10, 0, 4'h1);
    run(0, 0, 0, 100);
    chk("t1_seed_const", 32'(seed), 32'(7'b0000111));

    // T2: payload words, seed 1011101
    build_frame(7'b1011101, 10, 1, 4'h3);
    run(0, 0, 0, 100);

    // T3: T1 under output back-pressure and input gaps
    build_frame(7'b1111111, 10, 0, 4'h1);
    run(1, 1, 0, 300);

    // T4: back-to-back frames, different seeds, no idle between
    build_frame(7'b1111111, 5, 0, 4'h8);
    build_frame(7'b1011101, 5, 0, 4'hA);
    run(0, 0, 0, 100);

    // T5: reset after beat 3 of a frame, then a fresh frame with seed 0101010
    build_frame(7'b1011101, 10, 2, 4'h2);
    run(0, 0, 3, 100);
    chk("t5_pre_valid", 32'(m_axis_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("t5_rst_seed", 32'(seed), 32'd0);
    in_q.delete();
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    build_frame(7'b0101010, 6, 2, 4'h4);
    run(0, 0, 0, 100);

    // T6: single-beat frames; each one must restart seed recovery
    in_q.push_back('{data: 24'h000070, last: 1'b1, user: 4'h6});
    exp_q.push_back('{data: 24'h934F00, last: 1'b1, user: 4'h6, seed: 7'h07});
    in_q.push_back('{data: 24'h000070, last: 1'b1, user: 4'h7});
    exp_q.push_back('{data: 24'h934F00, last: 1'b1, user: 4'h7, seed: 7'h07});
    in_q.push_back('{data: 24'h934F70, last: 1'b1, user: 4'h9});
    exp_q.push_back('{data: 24'h000000, last: 1'b1, user: 4'h9, seed: 7'h07});
    run(0, 0, 0, 50);
    chk("t6_seed_hold", 32'(seed), 32'(7'h07));

    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
